present_host_if: RTL and testbench
==================================

# present_host_if

Host-side load/unload stage for the PRESENT-80 core, directly upstream and downstream of the round control logic. It gathers a 64-bit plaintext and an 80-bit key from a 16-bit valid/ready write stream, then issues the one-cycle start pulse (`sta`) to the core. It waits for the core's ready pulse, captures the 64-bit ciphertext and streams it out as four 16-bit words. It also flags a core that fails to finish in time.

## Interface
Parameters:
- `TMO`, default 40: maximum number of cycles in WAIT before a timeout is declared. Legal range 34..255.

Ports:
- `ck` in 1: rising-edge clock. Single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `in_vld` in 1: host write word valid.
- `in_rdy` out 1: block accepts a write word.
- `in_dat` in 16: write word.
- `out_vld` out 1: ciphertext word valid.
- `out_rdy` in 1: host accepts the ciphertext word.
- `out_dat` out 16: ciphertext word.
- `busy` out 1: high in START and WAIT.
- `err` out 1: sticky timeout flag. Cleared by `rst` or by the first accepted word of the next load.
- `sta` out 1: one-cycle start pulse to the core.
- `pt` out 64: plaintext to the core.
- `key` out 80: key to the core.
- `crdy` in 1: ready pulse from the core control.
- `ct` in 64: ciphertext from the core datapath.

## Operation
- States: LOAD, START, WAIT, DRAIN. Reset state is LOAD.
- Reset values: `in_rdy`=1 (LOAD), `out_vld`=0, `out_dat`=0, `busy`=0, `err`=0, `sta`=0, `pt`=0, `key`=0, word counter `wc`=0, timeout counter=0, captured ciphertext=0.
- LOAD:
  - `in_rdy`=1. Each cycle with `in_vld`=1 is a transfer.
  - Word index `wc` (4 bits), 0..8. Words 0-3 form `pt[63:0]`, most significant word first (word 0 = `pt[63:48]`).
  - Words 4-8 form `key[79:0]`, most significant word first (word 4 = `key[79:64]`).
  - Each transfer increments `wc`. The transfer at `wc`=8 moves to START and clears `wc`.
- START:
  - `sta`=1 for exactly this one cycle. `in_rdy`=0.
  - Next state is WAIT. The timeout counter is cleared.
- WAIT:
  - `pt` and `key` are held stable.
  - When `crdy`=1: latch `ct` into the capture register, go to DRAIN, and set `wc`=0.
  - Otherwise the timeout counter increments. When it reaches `TMO`: set `err`=1, capture `ct` anyway, and go to DRAIN.
- DRAIN:
  - `out_vld`=1. `out_dat` = captured word `wc`, most significant word first (word 0 = captured `ct[63:48]`).
  - A transfer occurs when `out_rdy`=1. Each transfer advances `wc`.
  - The transfer of word 3 moves to LOAD with `wc`=0. `out_vld` drops on the next cycle.
  - `out_dat` is held stable while `out_vld`=1 and `out_rdy`=0.
- `crdy` outside WAIT is ignored. `in_vld` outside LOAD is ignored: no transfer, and the data is not consumed.
- `pt` and `key` keep their last loaded values until overwritten word by word in the next LOAD.
- `rst` in any state forces all registers to their reset values on the next edge. This includes mid-load and mid-drain; partially loaded words are discarded.

## Timing
- Load latency: the 9th accepted word at edge n puts the block in START during cycle n+1, with `sta`=1 in that cycle only.
- Core latency: if `sta` is sampled high at edge t, `crdy` is high during cycle t+33. WAIT therefore sees `crdy` on its 33rd cycle.
- Capture: `ct` is latched at the edge where `crdy`=1. `out_vld` rises in the following cycle.
- Minimum period per block: 9 load cycles + 1 START + 33 WAIT + 4 DRAIN = 47 cycles, with continuous `in_vld` and `out_rdy`.
- No combinational path from `in_vld` or `out_rdy` to `in_rdy` or `out_vld`. Ready and valid depend on state only.
- Timeout: `err` rises at the edge where the WAIT counter reaches `TMO`. With the default `TMO`, that is 40 cycles after entering WAIT.

## Test plan
- Load `pt`=0 and `key`=0, with `out_rdy` tied high:
  - `sta` pulses exactly once, 1 cycle after the 9th word.
  - The output words are 5579, C138, 7B22, 8445.
  - `err`=0.
- Load `pt`=FFFF_FFFF_FFFF_FFFF and `key`=all ones:
  - The output words are 3333, DCD3, 2132, 10D2.
  - `busy` is high for exactly 34 cycles.
- Toggle `in_vld` randomly and stall `out_rdy` for 5 cycles on each word:
  - Same results as the two vectors above.
  - `out_dat` is stable during stalls.
  - No word is lost or duplicated.
- Hold `crdy`=0 in WAIT:
  - `err`=1 exactly `TMO` cycles after entering WAIT.
  - DRAIN still outputs 4 words, then the block returns to LOAD.
  - The next accepted word clears `err`.
- Assert `rst` after 5 load words, then load a full vector:
  - The result matches the vector; the pre-reset words have no effect.
- Assert `rst` during DRAIN after 2 words:
  - `out_vld`=0 on the next cycle.
  - `in_rdy`=1.
  - All outputs return to their reset values.

Source files
------------

// File: rtl/present_host_if_if.sv
// Host-side streams of the PRESENT-80 load/unload stage.
// The write stream carries plaintext and key words into the block.
// The read stream carries ciphertext words back to the host.
interface present_host_if_if;
    logic        in_vld;
    logic        in_rdy;
    logic [15:0] in_dat;
    logic        out_vld;
    logic        out_rdy;
    logic [15:0] out_dat;

    // Host side: drives write words and read acceptance.
    modport master (
        output in_vld, in_dat, out_rdy,
        input  in_rdy, out_vld, out_dat
    );

    // Block side: accepts write words and presents ciphertext words.
    modport slave (
        input  in_vld, in_dat, out_rdy,
        output in_rdy, out_vld, out_dat
    );
endinterface

// File: rtl/present_host_if.sv
// present_host_if: load/unload stage around the PRESENT-80 round control.
// Sequence per block:
//   1. Collect nine 16-bit words: four plaintext words, then five key words,
//      most significant word first in each group.
//   2. Pulse sta for one cycle.
//   3. Wait for the core's crdy pulse, or time out after TMO cycles.
//   4. Stream the captured ciphertext out as four words, most significant first.
// Ready and valid toward the host are registered and depend on state only.
module present_host_if #(
    parameter int unsigned TMO = 40    // legal range 34..255
) (
    input  logic               ck,
    input  logic               rst,
    present_host_if_if.slave   host,
    output logic               busy,
    output logic               err,
    output logic               sta,
    output logic [63:0]        pt,
    output logic [79:0]        key,
    input  logic               crdy,
    input  logic [63:0]        ct
);

    typedef enum logic [1:0] {LOAD, START, WAIT, DRAIN} state_t;

    // The counter holds the number of WAIT cycles already spent without crdy.
    // The edge that would bring it to TMO is the timeout edge.
    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    state_t      state;
    logic [3:0]  wc;
    logic [7:0]  tcnt;
    logic [63:0] cap;
    logic        in_rdy_q;
    logic        out_vld_q;
    logic [15:0] out_dat_q;
    logic        wait_done;

    assign host.in_rdy  = in_rdy_q;
    assign host.out_vld = out_vld_q;
    assign host.out_dat = out_dat_q;

    // WAIT ends on the core's ready pulse or on the timeout edge.
    // In both cases the ciphertext input is captured.
    assign wait_done = crdy || (tcnt == TMO_LAST);

    // Selects ciphertext word idx, most significant word first.
    function automatic logic [15:0] ct_word(input logic [63:0] v, input logic [1:0] idx);
        case (idx)
            2'd0:    return v[63:48];
            2'd1:    return v[47:32];
            2'd2:    return v[31:16];
            default: return v[15:0];
        endcase
    endfunction

    // Control FSM with all host- and core-facing outputs registered.
    // NOTE: every register here uses <= so each branch reads the pre-edge values
    // of state, wc and tcnt, regardless of statement order.
    always_ff @(posedge ck) begin
        if (rst) begin
            state     <= LOAD;
            wc        <= 4'd0;
            tcnt      <= 8'd0;
            cap       <= 64'd0;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
            out_dat_q <= 16'd0;
            busy      <= 1'b0;
            err       <= 1'b0;
            sta       <= 1'b0;
            pt        <= 64'd0;
            key       <= 80'd0;
        end else begin
            case (state)
                LOAD: begin
                    if (host.in_vld) begin
                        // A new load begins, so the previous timeout no longer applies.
                        err <= 1'b0;
                        case (wc)
                            4'd0:    pt[63:48]  <= host.in_dat;
                            4'd1:    pt[47:32]  <= host.in_dat;
                            4'd2:    pt[31:16]  <= host.in_dat;
                            4'd3:    pt[15:0]   <= host.in_dat;
                            4'd4:    key[79:64] <= host.in_dat;
                            4'd5:    key[63:48] <= host.in_dat;
                            4'd6:    key[47:32] <= host.in_dat;
                            4'd7:    key[31:16] <= host.in_dat;
                            4'd8:    key[15:0]  <= host.in_dat;
                            default: ;
                        endcase
                        if (wc >= 4'd8) begin
                            wc       <= 4'd0;
                            state    <= START;
                            in_rdy_q <= 1'b0;
                            sta      <= 1'b1;
                            busy     <= 1'b1;
                        end else begin
                            wc <= wc + 4'd1;
                        end
                    end
                end

                START: begin
                    sta   <= 1'b0;
                    tcnt  <= 8'd0;
                    state <= WAIT;
                end

                WAIT: begin
                    if (wait_done) begin
                        if (!crdy) begin
                            err <= 1'b1;
                        end
                        cap       <= ct;
                        out_dat_q <= ct[63:48];
                        out_vld_q <= 1'b1;
                        busy      <= 1'b0;
                        wc        <= 4'd0;
                        state     <= DRAIN;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end

                DRAIN: begin
                    if (host.out_rdy) begin
                        if (wc[1:0] == 2'd3) begin
                            wc        <= 4'd0;
                            out_vld_q <= 1'b0;
                            in_rdy_q  <= 1'b1;
                            state     <= LOAD;
                        end else begin
                            wc        <= wc + 4'd1;
                            out_dat_q <= ct_word(cap, wc[1:0] + 2'd1);
                        end
                    end
                end

                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_present_host_if.sv
// Directed bench for present_host_if.
// A small core model answers each sta pulse with crdy 33 cycles later.
// It returns the published PRESENT-80 ciphertexts for the all-zero and
// all-one vectors, and a fixed marker for any other vector.
module tb_present_host_if;
    localparam int TMO = 40;
    localparam logic [63:0] CT0 = 64'h5579_C138_7B22_8445;  // pt=0, key=0
    localparam logic [63:0] CT1 = 64'h3333_DCD3_2132_10D2;  // pt=1s, key=1s
    localparam logic [63:0] CTX = 64'hA5A5_0F0F_3C3C_9696;  // any other vector
    localparam logic [63:0] PT1 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [79:0] KEY1 = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;

    logic        ck = 1'b0;
    logic        rst;
    logic        busy;
    logic        err;
    logic        sta;
    logic [63:0] pt;
    logic [79:0] key;
    logic        crdy;
    logic [63:0] ct;

    present_host_if_if bus ();

    present_host_if #(.TMO(TMO)) dut (
        .ck   (ck),
        .rst  (rst),
        .host (bus),
        .busy (busy),
        .err  (err),
        .sta  (sta),
        .pt   (pt),
        .key  (key),
        .crdy (crdy),
        .ct   (ct)
    );

    always #5 ck = ~ck;

    // Core model: crdy is high in the 33rd cycle after sta is sampled.
    logic core_en;
    int   core_cnt = 0;
    always @(posedge ck) begin
        if (rst)                 core_cnt <= 0;
        else if (sta)            core_cnt <= 1;
        else if (core_cnt == 33) core_cnt <= 0;
        else if (core_cnt != 0)  core_cnt <= core_cnt + 1;
    end
    assign crdy = core_en && (core_cnt == 33);
    assign ct   = (pt == 64'd0 && key == 80'd0) ? CT0 :
                  (&pt && &key)                 ? CT1 : CTX;

    // Event monitor: edge numbers of handshakes and running activity counts.
    int   cyc = 0, last_acc = 0, sta_cyc = 0, sta_cnt = 0;
    int   err_rise = 0, ovld_rise = 0, busy_cnt = 0, out_acc_cnt = 0;
    logic err_q = 1'b0, ovld_q = 1'b0;
    always @(posedge ck) begin
        cyc <= cyc + 1;
        if (bus.in_vld && bus.in_rdy) last_acc <= cyc;
        if (sta) begin
            sta_cyc <= cyc;
            sta_cnt <= sta_cnt + 1;
        end
        if (busy) busy_cnt <= busy_cnt + 1;
        if (bus.out_vld && bus.out_rdy) out_acc_cnt <= out_acc_cnt + 1;
        err_q  <= err;
        ovld_q <= bus.out_vld;
        if (err && !err_q) err_rise <= cyc;
        if (bus.out_vld && !ovld_q) ovld_rise <= cyc;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        bus.in_vld = 1'b0;
        bus.out_rdy = 1'b0;
        repeat (2) @(negedge ck);
        rst = 1'b0;
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, " in_rdy"},  bus.in_rdy,  1);
        check({pfx, " out_vld"}, bus.out_vld, 0);
        check({pfx, " out_dat"}, bus.out_dat, 0);
        check({pfx, " busy"},    busy,        0);
        check({pfx, " err"},     err,         0);
        check({pfx, " sta"},     sta,         0);
        check({pfx, " pt"},      pt,          0);
        check({pfx, " key"},     key,         0);
    endtask

    // Writes the nine words; returns at the negedge of the START cycle.
    task automatic load_vector(input logic [63:0] p, input logic [79:0] k, input bit gaps);
        logic [15:0] w [9];
        int g;
        w[0] = p[63:48]; w[1] = p[47:32]; w[2] = p[31:16]; w[3] = p[15:0];
        w[4] = k[79:64]; w[5] = k[63:48]; w[6] = k[47:32]; w[7] = k[31:16];
        w[8] = k[15:0];
        for (int i = 0; i < 9; i++) begin
            if (gaps) begin
                g = int'($urandom_range(0, 3));
                repeat (g) begin
                    bus.in_vld = 1'b0;
                    bus.in_dat = 16'($urandom);
                    @(negedge ck);
                end
            end
            bus.in_vld = 1'b1;
            bus.in_dat = w[i];
            @(negedge ck);
            if (i == 0) check("err cleared by first word", err, 0);
        end
        bus.in_vld = 1'b0;
        bus.in_dat = 16'hDEAD;
        check("start sta",    sta,        1);
        check("start busy",   busy,       1);
        check("start in_rdy", bus.in_rdy, 0);
        check("start pt",     pt,         p);
        check("start key",    key,        k);
    endtask

    // Optionally pokes in_vld during WAIT, then drains nwords ciphertext words.
    task automatic wait_and_drain(input logic [63:0] exp_ct, input int nwords, input bit stall,
                                  input bit poke, input logic [63:0] p, input logic [79:0] k);
        int n;
        int acc0;
        logic [15:0] e;
        acc0 = out_acc_cnt;
        bus.out_rdy = !stall;
        n = 0;
        while (!bus.out_vld && n < 200) begin
            if (poke) begin
                bus.in_vld = 1'b1;
                bus.in_dat = 16'hBAD0 ^ 16'(n);
            end
            @(negedge ck);
            n++;
        end
        bus.in_vld = 1'b0;
        check("out_vld rises within bound", bus.out_vld, 1);
        if (!bus.out_vld) return;
        for (int i = 0; i < nwords; i++) begin
            e = exp_ct[63 - 16*i -: 16];
            if (stall) begin
                bus.out_rdy = 1'b0;
                repeat (5) begin
                    check($sformatf("stall word%0d vld", i), bus.out_vld, 1);
                    check($sformatf("stall word%0d dat", i), bus.out_dat, e);
                    @(negedge ck);
                end
            end
            bus.out_rdy = 1'b1;
            check($sformatf("word%0d vld", i), bus.out_vld, 1);
            check($sformatf("word%0d dat", i), bus.out_dat, e);
            @(negedge ck);
        end
        if (nwords == 4) begin
            check("drain end out_vld", bus.out_vld, 0);
            check("drain end in_rdy",  bus.in_rdy,  1);
            check("drain word count",  out_acc_cnt - acc0, 4);
            check("pt held",           pt,  p);
            check("key held",          key, k);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int s0;
        core_en     = 1'b1;
        rst         = 1'b1;
        bus.in_vld  = 1'b0;
        bus.in_dat  = 16'd0;
        bus.out_rdy = 1'b0;
        do_reset();
        check_reset("reset");

        // Zero vector, out_rdy held high, WAIT poked with in_vld.
        b0 = busy_cnt;
        s0 = sta_cnt;
        load_vector(64'd0, 80'd0, 1'b0);
        wait_and_drain(CT0, 4, 1'b0, 1'b1, 64'd0, 80'd0);
        check("zero sta pulses",      sta_cnt - s0,        1);
        check("zero sta after 9th",   sta_cyc - last_acc,  1);
        check("zero err",             err,                 0);
        check("zero out_vld latency", ovld_rise - sta_cyc, 34);
        check("zero busy cycles",     busy_cnt - b0,       34);

        // All-ones vector.
        b0 = busy_cnt;
        load_vector(PT1, KEY1, 1'b0);
        wait_and_drain(CT1, 4, 1'b0, 1'b0, PT1, KEY1);
        check("ones busy cycles", busy_cnt - b0, 34);

        // Both vectors again with random write gaps and read stalls.
        load_vector(64'd0, 80'd0, 1'b1);
        wait_and_drain(CT0, 4, 1'b1, 1'b0, 64'd0, 80'd0);
        load_vector(PT1, KEY1, 1'b1);
        wait_and_drain(CT1, 4, 1'b1, 1'b0, PT1, KEY1);

        // Timeout: the core never answers.
        core_en = 1'b0;
        b0 = busy_cnt;
        load_vector(64'h1111_1111_1111_1111, 80'h2222_2222_2222_2222_2222, 1'b0);
        wait_and_drain(CTX, 4, 1'b0, 1'b0, 64'h1111_1111_1111_1111, 80'h2222_2222_2222_2222_2222);
        check("timeout err set",      err,                1);
        check("timeout err latency",  err_rise - sta_cyc, TMO + 1);
        check("timeout busy cycles",  busy_cnt - b0,      TMO + 1);
        core_en = 1'b1;
        repeat (2) @(negedge ck);
        check("timeout err sticky", err, 1);
        load_vector(64'd0, 80'd0, 1'b0);
        wait_and_drain(CT0, 4, 1'b0, 1'b0, 64'd0, 80'd0);

        // Reset after five load words, then a full vector.
        for (int i = 0; i < 5; i++) begin
            bus.in_vld = 1'b1;
            bus.in_dat = 16'h1234 + 16'(i);
            @(negedge ck);
        end
        bus.in_vld = 1'b0;
        do_reset();
        check_reset("mid-load reset");
        load_vector(PT1, KEY1, 1'b0);
        wait_and_drain(CT1, 4, 1'b0, 1'b0, PT1, KEY1);

        // Reset during DRAIN after two words.
        load_vector(64'd0, 80'd0, 1'b0);
        wait_and_drain(CT0, 2, 1'b0, 1'b0, 64'd0, 80'd0);
        rst = 1'b1;
        @(negedge ck);
        check_reset("mid-drain reset");
        rst = 1'b0;
        load_vector(PT1, KEY1, 1'b0);
        wait_and_drain(CT1, 4, 1'b0, 1'b0, PT1, KEY1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
